ram_port_arbiter: RTL and testbench

- Round-robin arbiter sharing one port of the team's synchronous dual-port RAM among NUM_REQ requesters.
- Issues at most one read or write per cycle to the RAM port and routes 1-cycle-latency read data back to the issuing requester.
- Supports a per-requester lock for atomic multi-access sequences, bounded by a lock timeout.
- Sits between client engines (DMA, CPU bridge, etc.) and port A or port B of the RAM.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_port_arbiter_rr_pick.sv | 42 ++++
 rtl/ram_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
// Build option: define RAM_ARB_GRANT_CNT_EN to add per-requester grant counters.
package ram_arb_pkg;

    typedef enum logic [0:0] {
        ARB_S    = 1'b0,
        LOCKED_S = 1'b1
    } arb_state_e;

    localparam int GRANT_CNT_W = 16;

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    idx_s;
    logic               found_s;
    logic               hit_s;
    int                 pos_s;

    // Scan from ptr upward; the first valid requester wins.
    always_comb begin
        grant_s = {NUM_REQ{1'b0}};
        idx_s   = {ID_W{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        pos_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s          = (int'(ptr) + k) % NUM_REQ;
            hit_s          = valid[pos_s] & ~found_s;
            grant_s[pos_s] = hit_s;
            idx_s          = hit_s ? ID_W'(pos_s) : idx_s;
            found_s        = found_s | hit_s;
        end
    end

    assign grant = grant_s;
    assign idx   = idx_s;
    assign any   = found_s;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with lock support.
// Build option: RAM_ARB_GRANT_CNT_EN adds the grant_cnt output (16-bit saturating counters).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_din,
    output logic                             ram_we,
`ifdef RAM_ARB_GRANT_CNT_EN
    output logic [NUM_REQ*GRANT_CNT_W-1:0]   grant_cnt,
`endif
    input  logic [DATA_WIDTH-1:0]            ram_dout
);

    localparam int ID_W   = id_width(NUM_REQ);
    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e          state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     owner_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic                rsp_pend_r;
    logic [LCNT_W-1:0]   lock_cnt_r;
    logic [LCNT_W-1:0]   lock_cnt_inc_s;

    logic [NUM_REQ-1:0]  owner_mask_s;
    logic [NUM_REQ-1:0]  cand_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]     gnt_idx_s;
    logic                gnt_any_s;
    logic                xfer_we_s;
    logic                xfer_lock_s;
    logic                own_lock_s;
    logic [NUM_REQ-1:0]  rsp_valid_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_din_s;

    // Decode the lock owner into a one-hot mask.
    always_comb begin
        owner_mask_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_mask_s[i] = (owner_r == ID_W'(i));
        end
    end

    // While locked only the owner may compete; nothing is granted during reset.
    always_comb begin
        if (rst) begin
            cand_s = {NUM_REQ{1'b0}};
        end else if (state_r == LOCKED_S) begin
            cand_s = req_valid & owner_mask_s;
        end else begin
            cand_s = req_valid;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid (cand_s),
        .ptr   (rr_ptr_r),
        .grant (gnt_s),
        .idx   (gnt_idx_s),
        .any   (gnt_any_s)
    );

    // One-hot grant steers the winner's address and data onto the RAM port.
    always_comb begin
        ram_addr_s = {ADDR_WIDTH{1'b0}};
        ram_din_s  = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            ram_addr_s = ram_addr_s | ({ADDR_WIDTH{gnt_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            ram_din_s  = ram_din_s  | ({DATA_WIDTH{gnt_s[i]}} & req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    assign xfer_we_s      = |(req_we & gnt_s);
    assign xfer_lock_s    = |(req_lock & gnt_s);
    assign own_lock_s     = |(req_lock & owner_mask_s);
    assign lock_cnt_inc_s = lock_cnt_r + LCNT_W'(1);

    assign req_ready = gnt_s;
    assign ram_addr  = ram_addr_s;
    assign ram_din   = ram_din_s;
    assign ram_we    = xfer_we_s;

    // Arbitration FSM, round-robin pointer, lock counter and read-response pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ARB_S;
            rr_ptr_r   <= {ID_W{1'b0}};
            owner_r    <= {ID_W{1'b0}};
            lock_cnt_r <= {LCNT_W{1'b0}};
            rsp_pend_r <= 1'b0;
            rsp_id_r   <= {ID_W{1'b0}};
        end else begin
            rsp_pend_r <= gnt_any_s & ~xfer_we_s;
            rsp_id_r   <= gnt_idx_s;
            case (state_r)
                ARB_S: begin
                    if (gnt_any_s) begin
                        rr_ptr_r <= ID_W'(wrap_inc(int'(gnt_idx_s), NUM_REQ));
                        // With LOCK_MAX of one the initiating transfer already exhausts the lock.
                        if (xfer_lock_s && (LOCK_MAX > 1)) begin
                            state_r    <= LOCKED_S;
                            owner_r    <= gnt_idx_s;
                            lock_cnt_r <= LCNT_W'(1);
                        end
                    end
                end
                LOCKED_S: begin
                    if (gnt_any_s) begin
                        if (!xfer_lock_s || (lock_cnt_inc_s == LCNT_W'(LOCK_MAX))) begin
                            state_r    <= ARB_S;
                            rr_ptr_r   <= ID_W'(wrap_inc(int'(owner_r), NUM_REQ));
                            lock_cnt_r <= {LCNT_W{1'b0}};
                        end else begin
                            lock_cnt_r <= lock_cnt_inc_s;
                        end
                    end else if (!own_lock_s) begin
                        state_r    <= ARB_S;
                        lock_cnt_r <= {LCNT_W{1'b0}};
                    end
                end
                default: begin
                    state_r    <= ARB_S;
                    lock_cnt_r <= {LCNT_W{1'b0}};
                end
            endcase
        end
    end

    // Response strobe to the requester whose read went out last cycle.
    always_comb begin
        rsp_valid_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_s[i] = rsp_pend_r & ~rst & (rsp_id_r == ID_W'(i));
        end
    end

    assign rsp_valid = rsp_valid_s;
    assign rsp_rdata = ram_dout;

`ifdef RAM_ARB_GRANT_CNT_EN
    logic [GRANT_CNT_W-1:0] gcnt_r [NUM_REQ];
    logic [NUM_REQ*GRANT_CNT_W-1:0] gcnt_flat_s;

    // Per-requester saturating transfer counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt_r[i] <= {GRANT_CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_s[i] && (gcnt_r[i] != {GRANT_CNT_W{1'b1}})) begin
                    gcnt_r[i] <= gcnt_r[i] + GRANT_CNT_W'(1);
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        gcnt_flat_s = {(NUM_REQ*GRANT_CNT_W){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            gcnt_flat_s[i*GRANT_CNT_W +: GRANT_CNT_W] = gcnt_r[i];
        end
    end

    assign grant_cnt = gcnt_flat_s;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural one-port RAM.
// Define RAM_ARB_GRANT_CNT_EN to also exercise the grant counters.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_we;
    logic [3:0]  req_lock;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
`ifdef RAM_ARB_GRANT_CNT_EN
    logic [63:0] grant_cnt;
`endif

    logic [7:0]  mem [16];
    int          n_checks;
    int          n_pass;

    ram_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
`ifdef RAM_ARB_GRANT_CNT_EN
        .grant_cnt (grant_cnt),
`endif
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: registered read, write-before-next-read, contents reload on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 16; a++) begin
                mem[a] <= 8'hC0 | 8'(a);
            end
            ram_dout <= 8'h00;
        end else begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
            end
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        req_valid = 4'hF;
        req_we    = 4'hF;
        req_lock  = 4'h0;
        req_addr  = 16'h0000;
        req_wdata = 32'h0000_0000;
        cyc();
        cyc();
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        cyc();

        // Fairness: all four read continuously; requester i reads addr i+8.
        rst       = 1'b0;
        req_we    = 4'h0;
        req_addr  = 16'hBA98;
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("fair_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            check("fair_addr", 32'(ram_addr), 32'(8 + (c % 4)));
            if (c > 0) begin
                check("fair_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << ((c - 1) % 4)));
                check("fair_rdata", 32'(rsp_rdata), 32'(8'hC8 + 8'((c - 1) % 4)));
            end
            cyc();
        end
        req_valid = 4'h0;
        #1;
        check("fair_last_rsp", 32'(rsp_valid), 32'h8);
        check("fair_last_rdata", 32'(rsp_rdata), 32'hCB);
        cyc();

        // Write then read-after-write through different requesters.
        req_valid = 4'b0010;
        req_we    = 4'b0010;
        req_addr  = 16'h0050;
        req_wdata = 32'h0000_A500;
        #1;
        check("wr_ready", 32'(req_ready), 32'h2);
        check("wr_ram_we", 32'(ram_we), 32'h1);
        check("wr_ram_addr", 32'(ram_addr), 32'h5);
        check("wr_ram_din", 32'(ram_din), 32'hA5);
        cyc();
        req_valid = 4'b0100;
        req_we    = 4'b0000;
        req_addr  = 16'h0500;
        #1;
        check("rd_ready", 32'(req_ready), 32'h4);
        check("rd_ram_we", 32'(ram_we), 32'h0);
        check("wr_no_rsp", 32'(rsp_valid), 32'h0);
        cyc();
        req_valid = 4'h0;
        #1;
        check("raw_rsp_valid", 32'(rsp_valid), 32'h4);
        check("raw_rdata", 32'(rsp_rdata), 32'hA5);
        cyc();

        // Lock by req0 across an idle cycle while req3 waits (rr_ptr is 3 here).
        req_addr  = 16'h2001;
        req_valid = 4'b0001;
        req_lock  = 4'b0001;
        #1;
        check("lk_t0_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b1000;
        #1;
        check("lk_idle_ready", 32'(req_ready), 32'h0);
        check("lk_rsp0", 32'(rsp_valid), 32'h1);
        cyc();
        req_valid = 4'b1001;
        #1;
        check("lk_t2_ready", 32'(req_ready), 32'h1);
        cyc();
        req_lock = 4'b0000;
        #1;
        check("lk_t3_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b1000;
        #1;
        check("lk_release_ready", 32'(req_ready), 32'h8);
        check("lk_rsp0_last", 32'(rsp_valid), 32'h1);
        cyc();

        // Lock released by an idle owner cycle: nobody is granted that cycle.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        #1;
        check("idle_rel_t0", 32'(req_ready), 32'h2);
        check("idle_rel_rsp3", 32'(rsp_valid), 32'h8);
        cyc();
        req_valid = 4'b1000;
        req_lock  = 4'b0000;
        #1;
        check("idle_rel_t1", 32'(req_ready), 32'h0);
        cyc();
        #1;
        check("idle_rel_t2", 32'(req_ready), 32'h8);
        cyc();

        // Lock timeout: req2 holds lock for LOCK_MAX=8 transfers, then req0 wins.
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        #1;
        check("to_first", 32'(req_ready), 32'h4);
        cyc();
        req_valid = 4'b0101;
        for (int k = 1; k < 8; k++) begin
            #1;
            check("to_locked", 32'(req_ready), 32'h4);
            cyc();
        end
        #1;
        check("to_forced", 32'(req_ready), 32'h1);
        cyc();
        #1;
        check("to_relock", 32'(req_ready), 32'h4);
        cyc();
        req_valid = 4'h0;
        req_lock  = 4'h0;
        #1;
        check("to_drop", 32'(req_ready), 32'h0);
        cyc();

        // Reset the cycle after a locked read is accepted.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        req_addr  = 16'h0040;
        #1;
        check("rr_accept", 32'(req_ready), 32'h2);
        cyc();
        rst       = 1'b1;
        req_valid = 4'h0;
        req_lock  = 4'h0;
        #1;
        check("rr_rsp_in_rst", 32'(rsp_valid), 32'h0);
        cyc();
        rst       = 1'b0;
        req_valid = 4'hF;
        #1;
        check("rr_rsp_after", 32'(rsp_valid), 32'h0);
        check("rr_grant0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'h0;
        #1;
        check("rr_rsp_new", 32'(rsp_valid), 32'h1);
        cyc();

`ifdef RAM_ARB_GRANT_CNT_EN
        // Saturation: 70000 transfers by req0 alone after a fresh reset.
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        req_valid = 4'b0001;
        req_we    = 4'b0001;
        repeat (70000) cyc();
        req_valid = 4'h0;
        #1;
        check("gcnt0_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
        for (int i = 1; i < 4; i++) begin
            check("gcnt_other", 32'(grant_cnt[i*16 +: 16]), 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
